// File: rtl/dev_test_mp_pkg.sv
// ----------------------------------------------------------------------------
// dev_test_mp_pkg
//   Shared definitions for the dev_test_mp test I/O device: CTRL register
//   offsets (relative to the CTRL block base), CAUSE field layout, the
//   interrupt handshake state enum and a helper that packs the CAUSE word.
// ----------------------------------------------------------------------------
package dev_test_mp_pkg;

    // Byte offsets of the control registers inside the CTRL block.
    localparam logic [31:0] PENDING_OFF = 32'h0;
    localparam logic [31:0] MASK_OFF    = 32'h4;
    localparam logic [31:0] CAUSE_OFF   = 32'h8;
    localparam logic [31:0] SNAP_OFF    = 32'hC;

    // CAUSE register layout: {busy[31], ch[4:0]}.
    localparam int CAUSE_BUSY_BIT = 31;
    localparam int CAUSE_CH_LSB   = 0;
    localparam int CAUSE_CH_W     = 5;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } irq_state_e;

    function automatic logic [31:0] pack_cause(input logic busy,
                                               input logic [CAUSE_CH_W-1:0] ch);
        logic [31:0] word;
        word                                      = '0;
        word[CAUSE_BUSY_BIT]                      = busy;
        word[CAUSE_CH_LSB +: CAUSE_CH_W]          = ch;
        return word;
    endfunction

endpackage

// File: rtl/dev_test_mp_irq.sv
// ----------------------------------------------------------------------------
// dev_test_mp_irq
//   Interrupt front end of dev_test_mp. Synchronises the bench IRQ lines,
//   turns rising edges into PENDING bits, holds the MASK register, picks the
//   lowest unmasked pending channel and runs the int_req/int_fin handshake.
// Ports
//   clk, rstn      clock, asynchronous active-low reset
//   irq_i          raw bench interrupt lines (asynchronous)
//   mask_wr_i      load mask_wdata_i into MASK this cycle
//   mask_wdata_i   new MASK value (byte enables already merged)
//   int_fin_i      1-cycle "interrupt finished" pulse from the SoC
//   int_req_o      interrupt request to the SoC
//   pending_o      PENDING register
//   mask_o         MASK register
//   busy_o         CAUSE.busy
//   cause_ch_o     CAUSE.ch, channel being serviced
// ----------------------------------------------------------------------------
module dev_test_mp_irq
    import dev_test_mp_pkg::*;
#(
    parameter int IRQ_CH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [IRQ_CH-1:0]     irq_i,
    input  logic                  mask_wr_i,
    input  logic [IRQ_CH-1:0]     mask_wdata_i,
    input  logic                  int_fin_i,
    output logic                  int_req_o,
    output logic [IRQ_CH-1:0]     pending_o,
    output logic [IRQ_CH-1:0]     mask_o,
    output logic                  busy_o,
    output logic [CAUSE_CH_W-1:0] cause_ch_o
);

    logic [IRQ_CH-1:0]     sync1_q, sync1_d;
    logic [IRQ_CH-1:0]     sync2_q, sync2_d;
    logic [IRQ_CH-1:0]     prev_q,  prev_d;
    logic [IRQ_CH-1:0]     pending_q, pending_d;
    logic [IRQ_CH-1:0]     mask_q, mask_d;
    logic [CAUSE_CH_W-1:0] ch_q, ch_d;
    irq_state_e            state_q, state_d;

    logic [IRQ_CH-1:0]     rise;
    logic [IRQ_CH-1:0]     active;
    logic [CAUSE_CH_W-1:0] lowest_ch;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the synchroniser chain
    // depends on this).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            ch_q      <= '0;
            state_q   <= IDLE;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            ch_q      <= ch_d;
            state_q   <= state_d;
        end
    end

    // Lowest-index unmasked pending channel.
    always_comb begin
        active    = pending_q & mask_q;
        lowest_ch = '0;
        for (int i = IRQ_CH - 1; i >= 0; i--) begin
            if (active[i]) begin
                lowest_ch = CAUSE_CH_W'(i);
            end
        end
    end

    // Next-state logic.
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        sync1_d   = irq_i;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        rise      = sync2_q & ~prev_q;
        mask_d    = mask_wr_i ? mask_wdata_i : mask_q;
        state_d   = state_q;
        ch_d      = ch_q;
        pending_d = pending_q;

        unique case (state_q)
            IDLE: begin
                if (|active) begin
                    state_d = REQ;
                    ch_d    = lowest_ch;
                end
            end
            REQ: begin
                if (int_fin_i) begin
                    state_d   = IDLE;
                    pending_d = pending_q & ~(IRQ_CH'(1) << ch_q);
                end
            end
            default: state_d = IDLE;
        endcase

        // A new edge arriving together with the clear wins.
        pending_d = pending_d | rise;
    end

    // Outputs are decoded straight from the state register.
    always_comb begin
        int_req_o  = (state_q == REQ);
        busy_o     = (state_q == REQ);
        pending_o  = pending_q;
        mask_o     = mask_q;
        cause_ch_o = ch_q;
    end

endmodule

// File: rtl/dev_test_mp.sv
// ----------------------------------------------------------------------------
// dev_test_mp
//   Test I/O device on one SoC bus slave slot. Exposes a read-only byte array
//   driven by the bench (IN), a read/write byte array seen by the bench (OUT)
//   and a CTRL block (PENDING, MASK, CAUSE, SNAP) for the interrupt channels.
//   Each access accepted in cycle N completes with bus_ready_o in N+1.
// Configuration
//   DEV_TEST_MP_SNAPSHOT_EN  IN reads come from a shadow copy of test_in_i
//                            loaded by any write to SNAP; otherwise IN reads
//                            sample test_in_i live and SNAP writes do nothing.
// Ports
//   clk, rstn                   clock, asynchronous active-low reset
//   bus_req_i/we_i/addr_i/be_i/wdata_i   slave access request
//   bus_rdata_o, bus_ready_o    response, one cycle after the request
//   test_irq_i                  bench interrupt lines (rising-edge)
//   test_in_i                   bench-driven byte array
//   test_out_o                  device-driven byte array
//   int_req_o, int_fin_i        interrupt handshake with the SoC
// ----------------------------------------------------------------------------
module dev_test_mp
    import dev_test_mp_pkg::*;
#(
    parameter int IN_BYTES  = 1024,
    parameter int OUT_BYTES = 1024,
    parameter int IRQ_CH    = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      bus_req_i,
    input  logic                      bus_we_i,
    input  logic [31:0]               bus_addr_i,
    input  logic [3:0]                bus_be_i,
    input  logic [31:0]               bus_wdata_i,
    output logic [31:0]               bus_rdata_o,
    output logic                      bus_ready_o,
    input  logic [IRQ_CH-1:0]         test_irq_i,
    input  logic [IN_BYTES-1:0][7:0]  test_in_i,
    output logic [OUT_BYTES-1:0][7:0] test_out_o,
    output logic                      int_req_o,
    input  logic                      int_fin_i
);

    localparam int          IN_AW     = $clog2(IN_BYTES);
    localparam int          OUT_AW    = $clog2(OUT_BYTES);
    localparam logic [31:0] OUT_BASE  = 32'(IN_BYTES);
    localparam logic [31:0] CTRL_BASE = 32'(IN_BYTES + OUT_BYTES);

    logic [31:0]               rdata_q, rdata_d;
    logic                      ready_q, ready_d;
    logic [OUT_BYTES-1:0][7:0] out_q, out_d;
    logic [IN_BYTES-1:0][7:0]  in_src;

    logic [31:0]               out_off;
    logic [IN_AW-1:0]          in_base;
    logic [OUT_AW-1:0]         out_base;
    logic                      in_hit, out_hit, pend_hit, mask_hit, cause_hit;
    logic                      wr_acc, rd_acc;

    logic                      mask_wr;
    logic [IRQ_CH-1:0]         mask_wdata;
    logic [IRQ_CH-1:0]         pending, mask;
    logic                      busy;
    logic [CAUSE_CH_W-1:0]     cause_ch;

    // Address decode.
    always_comb begin
        out_off   = bus_addr_i - OUT_BASE;
        in_hit    = (bus_addr_i < OUT_BASE);
        out_hit   = !in_hit && (out_off < 32'(OUT_BYTES));
        pend_hit  = (bus_addr_i == CTRL_BASE + PENDING_OFF);
        mask_hit  = (bus_addr_i == CTRL_BASE + MASK_OFF);
        cause_hit = (bus_addr_i == CTRL_BASE + CAUSE_OFF);
        in_base   = {bus_addr_i[IN_AW-1:2], 2'b00};
        out_base  = {out_off[OUT_AW-1:2], 2'b00};
        wr_acc    = bus_req_i && bus_we_i;
        rd_acc    = bus_req_i && !bus_we_i;
    end

    // MASK write with per-byte enables merged onto the current value.
    always_comb begin
        mask_wr    = wr_acc && mask_hit;
        mask_wdata = mask;
        for (int i = 0; i < IRQ_CH; i++) begin
            if (bus_be_i[i / 8]) begin
                mask_wdata[i] = bus_wdata_i[i];
            end
        end
    end

    // OUT array write.
    always_comb begin
        out_d = out_q;
        if (wr_acc && out_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_be_i[b]) begin
                    out_d[out_base + OUT_AW'(b)] = bus_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read mux; writes and unmapped reads return 0.
    always_comb begin
        ready_d = bus_req_i;
        rdata_d = '0;
        if (rd_acc) begin
            if (in_hit) begin
                for (int b = 0; b < 4; b++) begin
                    rdata_d[8*b +: 8] = in_src[in_base + IN_AW'(b)];
                end
            end else if (out_hit) begin
                for (int b = 0; b < 4; b++) begin
                    rdata_d[8*b +: 8] = out_q[out_base + OUT_AW'(b)];
                end
            end else if (pend_hit) begin
                rdata_d = 32'(pending);
            end else if (mask_hit) begin
                rdata_d = 32'(mask);
            end else if (cause_hit) begin
                rdata_d = pack_cause(busy, cause_ch);
            end
        end
    end

    // NOTE: the OUT array is an architectural register file that must read
    // back as zero after reset, so it sits in the reset branch rather than
    // being treated as an un-reset memory.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
            ready_q <= 1'b0;
            out_q   <= '0;
        end else begin
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            out_q   <= out_d;
        end
    end

`ifdef DEV_TEST_MP_SNAPSHOT_EN
    logic                     snap_hit;
    logic [IN_BYTES-1:0][7:0] shadow_q, shadow_d;

    always_comb begin
        snap_hit = (bus_addr_i == CTRL_BASE + SNAP_OFF);
        shadow_d = (wr_acc && snap_hit) ? test_in_i : shadow_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign in_src = shadow_q;
`else
    assign in_src = test_in_i;
`endif

    dev_test_mp_irq #(
        .IRQ_CH (IRQ_CH)
    ) u_irq (
        .clk          (clk),
        .rstn         (rstn),
        .irq_i        (test_irq_i),
        .mask_wr_i    (mask_wr),
        .mask_wdata_i (mask_wdata),
        .int_fin_i    (int_fin_i),
        .int_req_o    (int_req_o),
        .pending_o    (pending),
        .mask_o       (mask),
        .busy_o       (busy),
        .cause_ch_o   (cause_ch)
    );

    assign bus_rdata_o = rdata_q;
    assign bus_ready_o = ready_q;
    assign test_out_o  = out_q;

endmodule
